// File: rtl/lc3_fetch_pkg.sv
// Shared types and constants for the LC-3 instruction fetch stage.
package lc3_fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } fetch_state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] npc;
  } fetch_entry_t;

  localparam logic [15:0] PcResetDefault = 16'h3000;

endpackage

// File: rtl/lc3_fetch_fifo.sv
// Synchronous instruction buffer of fetch entries with flush; Depth must be a power of two.
module lc3_fetch_fifo
  import lc3_fetch_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned CntW  = $clog2(Depth) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  fetch_entry_t    data_i,
  input  logic            pop_i,
  output fetch_entry_t    data_o,
  output logic [CntW-1:0] count_o,
  output logic            empty_o,
  output logic            full_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign do_pop  = pop_i & ~empty_o;
  // A simultaneous pop frees the slot a push into a full buffer needs.
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/lc3_fetch_stage.sv
// LC-3 fetch stage: PC, single-outstanding imem request FSM, instruction buffer and
// decode-side delivery with back-pressure and branch redirect.
module lc3_fetch_stage
  import lc3_fetch_pkg::*;
#(
  parameter logic [15:0] PC_RESET   = PcResetDefault,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_fetch,
  input  logic        enable_updatePC,
  input  logic        br_taken,
  input  logic [15:0] taddr,
  input  logic        stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic [15:0] pc,
  output logic        enable_decode,
  output logic [15:0] dout,
  output logic [15:0] npc_out
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t    state_q, state_d;
  logic [15:0]     pc_q, pc_d;
  logic [15:0]     req_addr_q, req_addr_d;
  logic            stale_q, stale_d;
  logic            dec_valid_q;
  logic [15:0]     dout_q, npc_q;

  logic            redirect, push, pop, issue_ok;
  logic [CntW-1:0] fifo_count, cnt_proj;
  logic            fifo_empty, fifo_full;
  fetch_entry_t    push_entry, head;

  assign redirect   = br_taken & enable_updatePC;
  assign push       = (state_q == StWait) & imem_rvalid & ~stale_q & ~redirect;
  assign pop        = ~fifo_empty & enable_fetch & ~stall & ~redirect;
  // Issue against the post-cycle occupancy so the reply always has a slot.
  assign cnt_proj   = fifo_count + CntW'(push) - CntW'(pop);
  assign issue_ok   = enable_fetch & ~redirect & ~(fifo_full & ~pop) &
                      (cnt_proj < CntW'(FIFO_DEPTH));
  assign push_entry = '{instr: imem_rdata, npc: req_addr_q + 16'd1};

  lc3_fetch_fifo #(
    .Depth(FIFO_DEPTH),
    .CntW (CntW)
  ) u_fifo (
    .clk_i  (clock),
    .rst_ni (reset),
    .flush_i(redirect),
    .push_i (push),
    .data_i (push_entry),
    .pop_i  (pop),
    .data_o (head),
    .count_o(fifo_count),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    stale_d    = stale_q;
    unique case (state_q)
      StIdle: begin
        if (issue_ok) begin
          state_d    = StReq;
          req_addr_d = pc_q;
        end
      end
      StReq: begin
        if (imem_gnt) begin
          state_d = StWait;
          pc_d    = req_addr_q + 16'd1;
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          stale_d = 1'b0;
          if (issue_ok) begin
            state_d    = StReq;
            req_addr_d = pc_q;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Redirect overrides any PC increment; a request still awaiting its reply is marked stale.
    if (redirect) begin
      pc_d = taddr;
      if ((state_q == StReq) || ((state_q == StWait) && !imem_rvalid)) stale_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      pc_q        <= PC_RESET;
      req_addr_q  <= '0;
      stale_q     <= 1'b0;
      dec_valid_q <= 1'b0;
      dout_q      <= '0;
      npc_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      stale_q     <= stale_d;
      dec_valid_q <= pop;
      if (pop) begin
        dout_q <= head.instr;
        npc_q  <= head.npc;
      end
    end
  end

  assign imem_req      = (state_q == StReq);
  assign imem_addr     = req_addr_q;
  assign pc            = pc_q;
  assign enable_decode = dec_valid_q;
  assign dout          = dout_q;
  assign npc_out       = npc_q;

endmodule

// File: tb/tb_lc3_fetch_stage.sv
// Scoreboard bench for lc3_fetch_stage: a memory responder, a delivery monitor and directed phases.
module tb_lc3_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_fetch, enable_updatePC, br_taken, stall;
  logic [15:0] taddr;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [15:0] imem_addr, imem_rdata;
  logic [15:0] pc, dout, npc_out;
  logic        enable_decode;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [15:0] gnt_q[$];
  int          mem_lat = 1;

  always #5 clock = ~clock;

  assign imem_gnt = imem_req;

  lc3_fetch_stage dut (
    .clock          (clock),
    .reset          (reset),
    .enable_fetch   (enable_fetch),
    .enable_updatePC(enable_updatePC),
    .br_taken       (br_taken),
    .taddr          (taddr),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .pc             (pc),
    .enable_decode  (enable_decode),
    .dout           (dout),
    .npc_out        (npc_out)
  );

  // Memory image: 3000 holds 1234, every other word is the inverted address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a == 16'h3000) ? 16'h1234 : ~a;
  endfunction

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Memory responder: observe req/gnt mid-cycle, return data mem_lat cycles later.
  initial begin : mem_model
    int          lat_cnt;
    logic        pending;
    logic        g;
    logic [15:0] paddr;
    lat_cnt     = 0;
    pending     = 1'b0;
    paddr       = '0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        pending     = 1'b0;
        imem_rvalid = 1'b0;
      end else begin
        g           = imem_req & imem_gnt;
        imem_rvalid = 1'b0;
        if (pending) begin
          lat_cnt--;
          if (lat_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(paddr);
            pending     = 1'b0;
          end
        end
        if (g) begin
          pending = 1'b1;
          paddr   = imem_addr;
          lat_cnt = mem_lat;
          gnt_q.push_back(imem_addr);
        end
      end
    end
  end

  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clock);
      if (enable_decode) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_delivery: got dout=%h npc=%h expected none", dout, npc_out);
        end else begin
          e = exp_q.pop_front();
          check16("deliver_dout", dout, e[31:16]);
          check16("deliver_npc", npc_out, e[15:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic redirect_to(input logic [15:0] t);
    br_taken        = 1'b1;
    enable_updatePC = 1'b1;
    taddr           = t;
    step();
    br_taken        = 1'b0;
    enable_updatePC = 1'b0;
    gnt_q.delete();
  endtask

  task automatic expect_entry(input logic [15:0] instr, input logic [15:0] npc);
    exp_q.push_back({instr, npc});
  endtask

  task automatic wait_req(input logic [15:0] addr, input string name);
    int b;
    b = 0;
    do begin
      step();
      b++;
    end while (!(imem_req && imem_addr == addr) && b < 50);
    check_int(name, int'(imem_req && imem_addr == addr), 1);
  endtask

  // Release stall until n deliveries are seen, then re-stall before the next pop can happen.
  task automatic wait_deliveries(input int n, input string name);
    int seen;
    int budget;
    seen   = 0;
    budget = 0;
    stall  = 1'b0;
    while (seen < n && budget < 200) begin
      step();
      budget++;
      if (enable_decode) seen++;
    end
    stall = 1'b1;
    check_int({name, "_count"}, seen, n);
    step();
    check_int({name, "_queue_left"}, exp_q.size(), 0);
  endtask

  initial begin : main
    enable_fetch    = 1'b0;
    enable_updatePC = 1'b0;
    br_taken        = 1'b0;
    taddr           = '0;
    stall           = 1'b0;
    reset           = 1'b1;
    #1 reset        = 1'b0;
    repeat (3) step();

    check16("rst_imem_req", {15'd0, imem_req}, 16'd0);
    check16("rst_imem_addr", imem_addr, 16'h0000);
    check16("rst_enable_decode", {15'd0, enable_decode}, 16'd0);
    check16("rst_dout", dout, 16'h0000);
    check16("rst_npc_out", npc_out, 16'h0000);
    check16("rst_pc", pc, 16'h3000);

    // First fetch after reset
    enable_fetch = 1'b1;
    reset        = 1'b1;
    wait_req(16'h3000, "first_req_seen");
    check16("first_imem_addr", imem_addr, 16'h3000);
    step();
    check16("first_pc_after_gnt", pc, 16'h3001);
    expect_entry(16'h1234, 16'h3001);
    wait_deliveries(1, "first");

    // Decode stall: buffer fills with two entries and issue stops
    redirect_to(16'h3000);
    repeat (10) step();
    check_int("stall_req_count", gnt_q.size(), 2);
    if (gnt_q.size() == 2) begin
      check16("stall_req0_addr", gnt_q[0], 16'h3000);
      check16("stall_req1_addr", gnt_q[1], 16'h3001);
    end
    check16("stall_req_idle", {15'd0, imem_req}, 16'd0);
    expect_entry(16'h1234, 16'h3001);
    expect_entry(16'hCFFE, 16'h3002);
    wait_deliveries(2, "stall_release");

    // Redirect while waiting on a 3-cycle memory
    mem_lat = 3;
    redirect_to(16'h3010);
    wait_req(16'h3010, "wait_redirect_req_seen");
    step();
    check16("wait_state_no_req", {15'd0, imem_req}, 16'd0);
    redirect_to(16'h4000);
    check16("wait_redirect_pc", pc, 16'h4000);
    expect_entry(16'hBFFF, 16'h4001);
    expect_entry(16'hBFFE, 16'h4002);
    wait_deliveries(2, "wait_redirect");
    check_int("wait_redirect_has_req", int'(gnt_q.size() > 0), 1);
    if (gnt_q.size() > 0) check16("wait_redirect_first_addr", gnt_q[0], 16'h4000);

    // Redirect coinciding with grant of 3005
    mem_lat = 1;
    redirect_to(16'h3005);
    wait_req(16'h3005, "gnt_redirect_req_seen");
    redirect_to(16'h4000);
    check16("gnt_redirect_pc", pc, 16'h4000);
    expect_entry(16'hBFFF, 16'h4001);
    wait_deliveries(1, "gnt_redirect");
    check_int("gnt_redirect_has_req", int'(gnt_q.size() > 0), 1);
    if (gnt_q.size() > 0) check16("gnt_redirect_first_addr", gnt_q[0], 16'h4000);

    // PC wrap from FFFF to 0000
    redirect_to(16'hFFFF);
    expect_entry(16'h0000, 16'h0000);
    expect_entry(16'hFFFF, 16'h0001);
    wait_deliveries(2, "wrap");
    check_int("wrap_has_reqs", int'(gnt_q.size() >= 2), 1);
    if (gnt_q.size() >= 2) begin
      check16("wrap_addr0", gnt_q[0], 16'hFFFF);
      check16("wrap_addr1", gnt_q[1], 16'h0000);
    end

    // Asynchronous reset in the middle of a 3-cycle wait
    mem_lat = 3;
    redirect_to(16'h3020);
    wait_req(16'h3020, "midreset_req_seen");
    step();
    reset = 1'b0;
    #1;
    check16("midreset_imem_req", {15'd0, imem_req}, 16'd0);
    check16("midreset_imem_addr", imem_addr, 16'h0000);
    check16("midreset_enable_decode", {15'd0, enable_decode}, 16'd0);
    check16("midreset_dout", dout, 16'h0000);
    check16("midreset_npc_out", npc_out, 16'h0000);
    check16("midreset_pc", pc, 16'h3000);
    step();
    step();
    reset = 1'b1;
    gnt_q.delete();
    expect_entry(16'h1234, 16'h3001);
    wait_deliveries(1, "after_reset");
    check_int("after_reset_has_req", int'(gnt_q.size() > 0), 1);
    if (gnt_q.size() > 0) check16("after_reset_first_addr", gnt_q[0], 16'h3000);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
